// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared UART types and limits for the TX framer and the RX checker.
//   parity_t   : encoding of the 3-bit parity_type field (101..111 = none)
//   tx_state_t : transmit framer states
//   MIN/MAX_DATA_WIDTH : legal range for data bits per frame
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int MIN_DATA_WIDTH = 5;
    localparam int MAX_DATA_WIDTH = 9;

    typedef enum logic [2:0] {
        PAR_NONE  = 3'd0,
        PAR_ODD   = 3'd1,
        PAR_EVEN  = 3'd2,
        PAR_MARK  = 3'd3,
        PAR_SPACE = 3'd4
    } parity_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } tx_state_t;

    // True when the parity code reserves a parity slot in the frame.
    // Codes 101..111 are treated exactly like PAR_NONE.
    function automatic logic parity_enabled(input logic [2:0] code);
        logic en;
        case (code)
            PAR_ODD, PAR_EVEN, PAR_MARK, PAR_SPACE: en = 1'b1;
            default:                                en = 1'b0;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/uart_parity_acc.sv
// ---------------------------------------------------------------------------
// uart_parity_acc
// Serial parity accumulator plus parity-mode mux. The accumulator XORs in one
// bit per enable; the mux turns the accumulated value into the parity bit for
// the selected mode. Shared between the TX framer and the RX checker.
//
// Ports:
//   clock        in   system clock
//   reset        in   asynchronous active-high reset, clears the accumulator
//   clear        in   synchronous clear (start of a new word)
//   enable       in   XOR bit_in into the accumulator this cycle
//   bit_in       in   data bit being sent/received
//   parity_type  in   3-bit parity code (see uart_pkg::parity_t)
//   parity_bit   out  parity bit for the current accumulator value and mode
//   parity_en    out  mode reserves a parity slot in the frame
// ---------------------------------------------------------------------------
module uart_parity_acc
    import uart_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic       bit_in,
    input  logic [2:0] parity_type,
    output logic       parity_bit,
    output logic       parity_en
);

    logic acc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc <= 1'b0;
        end else if (clear) begin
            acc <= 1'b0;
        end else if (enable) begin
            acc <= acc ^ bit_in;
        end
    end

    // acc is the XOR of all data bits, i.e. 1 when the count of ones is odd.
    // Odd parity must make the total (data + parity) odd, hence ~acc.
    always_comb begin
        parity_bit = 1'b0;
        case (parity_type)
            PAR_ODD:   parity_bit = ~acc;
            PAR_EVEN:  parity_bit = acc;
            PAR_MARK:  parity_bit = 1'b1;
            PAR_SPACE: parity_bit = 1'b0;
            default:   parity_bit = 1'b0;
        endcase
    end

    assign parity_en = parity_enabled(parity_type);

endmodule

// File: rtl/uart_tx_framer.sv
// ---------------------------------------------------------------------------
// uart_tx_framer
// UART transmit framer. Accepts one word over valid/ready while idle and
// sends it LSB-first as: start bit, DATA_WIDTH data bits, optional parity
// bit, one or two stop bits. One bit per baud_tick; tx only changes on
// edges where baud_tick is high.
//
// Parameters:
//   DATA_WIDTH   data bits per frame, 5..9
// Ports:
//   clock        in   system clock
//   reset        in   asynchronous active-high reset
//   data_in      in   word to send, latched on accept
//   data_valid   in   word present on data_in
//   data_ready   out  framer is idle and can accept a word
//   parity_type  in   parity code, latched on accept
//   stop_bits    in   0 = one stop bit, 1 = two, latched on accept
//   baud_tick    in   one-cycle strobe per bit period
//   tx           out  registered serial line, idle high
//   busy         out  a frame is in progress
//   done         out  one-cycle pulse after the last stop bit ends
//
// State table:
//   state  | meaning
//   IDLE   | line high, waiting for a word; baud_tick ignored
//   ARMED  | word latched, waiting for the tick that begins the start bit
//   START  | start bit (0) on the line
//   DATA   | data bit bit_cnt on the line
//   PARITY | parity bit on the line
//   STOP   | stop bit on the line; stop_cnt selects first/second
// ---------------------------------------------------------------------------
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    input  logic [2:0]            parity_type,
    input  logic                  stop_bits,
    input  logic                  baud_tick,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);

    localparam int               CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    generate
        if (DATA_WIDTH < MIN_DATA_WIDTH || DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_width
            $error("uart_tx_framer: DATA_WIDTH must be within 5..9");
        end
    endgenerate

    tx_state_t             state;
    tx_state_t             state_next;

    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] shift_next;
    logic [CNT_W-1:0]      bit_cnt;
    logic [CNT_W-1:0]      bit_cnt_next;
    logic                  stop_cnt;
    logic                  stop_cnt_next;
    logic [2:0]            par_q;
    logic                  two_stop_q;
    logic                  tx_next;
    logic                  done_next;

    logic                  load;
    logic                  acc_clear;
    logic                  acc_en;
    logic                  parity_bit;
    logic                  parity_en;

    uart_parity_acc u_parity (
        .clock       (clock),
        .reset       (reset),
        .clear       (acc_clear),
        .enable      (acc_en),
        .bit_in      (shift_reg[0]),
        .parity_type (par_q),
        .parity_bit  (parity_bit),
        .parity_en   (parity_en)
    );

    assign data_ready = (state == IDLE);
    assign busy       = (state != IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Each tick loads tx with the bit that the *next* state puts on the line,
    // so the state always names the bit currently being driven.
    always_comb begin
        state_next    = state;
        tx_next       = tx;
        shift_next    = shift_reg;
        bit_cnt_next  = bit_cnt;
        stop_cnt_next = stop_cnt;
        done_next     = 1'b0;
        load          = 1'b0;
        acc_clear     = 1'b0;
        acc_en        = 1'b0;

        case (state)
            IDLE: begin
                if (data_valid) begin
                    load          = 1'b1;
                    acc_clear     = 1'b1;
                    shift_next    = data_in;
                    bit_cnt_next  = '0;
                    stop_cnt_next = 1'b0;
                    state_next    = ARMED;
                end
            end

            ARMED: begin
                if (baud_tick) begin
                    tx_next    = 1'b0;
                    state_next = START;
                end
            end

            START: begin
                if (baud_tick) begin
                    tx_next      = shift_reg[0];
                    shift_next   = shift_reg >> 1;
                    acc_en       = 1'b1;
                    bit_cnt_next = '0;
                    state_next   = DATA;
                end
            end

            DATA: begin
                if (baud_tick) begin
                    if (bit_cnt == LAST_BIT) begin
                        // Accumulator already holds every data bit here.
                        if (parity_en) begin
                            tx_next    = parity_bit;
                            state_next = PARITY;
                        end else begin
                            tx_next       = 1'b1;
                            stop_cnt_next = 1'b0;
                            state_next    = STOP;
                        end
                    end else begin
                        tx_next      = shift_reg[0];
                        shift_next   = shift_reg >> 1;
                        acc_en       = 1'b1;
                        bit_cnt_next = bit_cnt + CNT_W'(1);
                    end
                end
            end

            PARITY: begin
                if (baud_tick) begin
                    tx_next       = 1'b1;
                    stop_cnt_next = 1'b0;
                    state_next    = STOP;
                end
            end

            STOP: begin
                if (baud_tick) begin
                    if (two_stop_q && !stop_cnt) begin
                        stop_cnt_next = 1'b1;
                    end else begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end

            default: begin
                tx_next    = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx         <= 1'b1;
            done       <= 1'b0;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            par_q      <= PAR_NONE;
            two_stop_q <= 1'b0;
        end else begin
            tx        <= tx_next;
            done      <= done_next;
            shift_reg <= shift_next;
            bit_cnt   <= bit_cnt_next;
            stop_cnt  <= stop_cnt_next;
            if (load) begin
                par_q      <= parity_type;
                two_stop_q <= stop_bits;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_framer
// Two framers (DATA_WIDTH 8 and 5) driven from shared clock/tick/parity/stop
// inputs. A frame-level model builds each frame's bit list on accept and pops
// one bit per tick; a compare process checks every cycle. Directed frames pin
// the model against hand-computed waveforms, then random frames follow.
// ---------------------------------------------------------------------------
module tb_uart_tx_framer;

    logic       clock       = 1'b0;
    logic       reset       = 1'b1;
    logic       baud_tick   = 1'b0;
    logic [2:0] parity_type = 3'd0;
    logic       stop_bits   = 1'b0;
    logic [7:0] data8       = 8'h00;
    logic [4:0] data5       = 5'h00;
    logic       valid8      = 1'b0;
    logic       valid5      = 1'b0;

    logic tx8, ready8, busy8, done8;
    logic tx5, ready5, busy5, done5;

    int checks      = 0;
    int failures    = 0;
    int tick_period = 4;

    // model state, index 0 = width 8, index 1 = width 5
    logic        m_busy   [2];
    logic        m_tx     [2];
    logic        m_done   [2];
    logic        m_ticked [2];
    logic [15:0] m_bits   [2];
    int          m_len    [2];
    int          m_pos    [2];

    logic        trace    [2][64];
    int          trace_n  [2];
    int          done_cnt [2];

    uart_tx_framer #(.DATA_WIDTH(8)) dut8 (
        .clock       (clock),
        .reset       (reset),
        .data_in     (data8),
        .data_valid  (valid8),
        .data_ready  (ready8),
        .parity_type (parity_type),
        .stop_bits   (stop_bits),
        .baud_tick   (baud_tick),
        .tx          (tx8),
        .busy        (busy8),
        .done        (done8)
    );

    uart_tx_framer #(.DATA_WIDTH(5)) dut5 (
        .clock       (clock),
        .reset       (reset),
        .data_in     (data5),
        .data_valid  (valid5),
        .data_ready  (ready5),
        .parity_type (parity_type),
        .stop_bits   (stop_bits),
        .baud_tick   (baud_tick),
        .tx          (tx5),
        .busy        (busy5),
        .done        (done5)
    );

    always #5 clock = ~clock;

    initial begin
        forever begin
            repeat (tick_period - 1) @(negedge clock);
            baud_tick = 1'b1;
            @(negedge clock);
            baud_tick = 1'b0;
        end
    end

    // Frame as a list of line values, in transmit order.
    function automatic int build_frame(input int w, input logic [8:0] d, input logic [2:0] pt,
                                       input logic sb, output logic [15:0] bits);
        int n;
        int ones;
        bits = '1;
        n    = 0;
        ones = 0;
        bits[n] = 1'b0;
        n++;
        for (int k = 0; k < w; k++) begin
            bits[n] = d[k];
            if (d[k]) ones++;
            n++;
        end
        case (pt)
            3'd1: begin bits[n] = ((ones % 2) == 0); n++; end
            3'd2: begin bits[n] = ((ones % 2) == 1); n++; end
            3'd3: begin bits[n] = 1'b1;              n++; end
            3'd4: begin bits[n] = 1'b0;              n++; end
            default: ;
        endcase
        bits[n] = 1'b1;
        n++;
        if (sb) begin
            bits[n] = 1'b1;
            n++;
        end
        return n;
    endfunction

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            m_done[i]   = 1'b0;
            m_ticked[i] = 1'b0;
            if (reset) begin
                m_busy[i] = 1'b0;
                m_tx[i]   = 1'b1;
                m_pos[i]  = 0;
                m_len[i]  = 0;
            end else if (!m_busy[i]) begin
                if ((i == 0) ? valid8 : valid5) begin
                    m_len[i]  = build_frame((i == 0) ? 8 : 5,
                                            (i == 0) ? 9'(data8) : 9'(data5),
                                            parity_type, stop_bits, m_bits[i]);
                    m_pos[i]  = 0;
                    m_busy[i] = 1'b1;
                end
            end else if (baud_tick) begin
                m_ticked[i] = 1'b1;
                if (m_pos[i] < m_len[i]) begin
                    m_tx[i] = m_bits[i][m_pos[i]];
                    m_pos[i]++;
                end else begin
                    m_busy[i] = 1'b0;
                    m_done[i] = 1'b1;
                    m_tx[i]   = 1'b1;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clock or posedge reset);
            model_step();
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clock);
            check("tx_w8",    32'(tx8),    32'(m_tx[0]));
            check("ready_w8", 32'(ready8), 32'(!m_busy[0]));
            check("busy_w8",  32'(busy8),  32'(m_busy[0]));
            check("done_w8",  32'(done8),  32'(m_done[0]));
            check("tx_w5",    32'(tx5),    32'(m_tx[1]));
            check("ready_w5", 32'(ready5), 32'(!m_busy[1]));
            check("busy_w5",  32'(busy5),  32'(m_busy[1]));
            check("done_w5",  32'(done5),  32'(m_done[1]));
            if (m_ticked[0] && trace_n[0] < 64) begin
                trace[0][trace_n[0]] = tx8;
                trace_n[0]++;
            end
            if (m_ticked[1] && trace_n[1] < 64) begin
                trace[1][trace_n[1]] = tx5;
                trace_n[1]++;
            end
            if (done8) done_cnt[0]++;
            if (done5) done_cnt[1]++;
        end
    end

    task automatic wait_model(input int inst, input logic level, input int budget, input string what);
        int n;
        n = 0;
        while (m_busy[inst] !== level && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (m_busy[inst] !== level) begin
            checks++;
            failures++;
            $display("FAIL timeout %s inst=%0d after %0d cycles", what, inst, n);
        end
    endtask

    task automatic send(input int inst, input logic [8:0] d, input logic [2:0] pt, input logic sb);
        wait_model(inst, 1'b0, 400, "idle_before_send");
        if (inst == 0) data8 = d[7:0];
        else           data5 = d[4:0];
        parity_type = pt;
        stop_bits   = sb;
        if (inst == 0) valid8 = 1'b1;
        else           valid5 = 1'b1;
        wait_model(inst, 1'b1, 50, "accept");
        if (inst == 0) valid8 = 1'b0;
        else           valid5 = 1'b0;
        // scramble inputs after accept; the frame in flight must not change
        parity_type = 3'($urandom);
        stop_bits   = 1'($urandom);
        if (inst == 0) data8 = 8'($urandom);
        else           data5 = 5'($urandom);
    endtask

    task automatic run_frame(input int inst, input logic [8:0] d, input logic [2:0] pt, input logic sb);
        wait_model(inst, 1'b0, 400, "idle_before_frame");
        trace_n[inst]  = 0;
        done_cnt[inst] = 0;
        send(inst, d, pt, sb);
        wait_model(inst, 1'b0, 400, "frame_end");
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic check_seq(input string name, input int inst, input logic [15:0] seq, input int n);
        for (int k = 0; k < n; k++) begin
            check(name, 32'(trace[inst][k]), 32'(seq[n-1-k]));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        int n;
        trace_n[0]  = 0;
        trace_n[1]  = 0;
        done_cnt[0] = 0;
        done_cnt[1] = 0;

        repeat (3) @(negedge clock);
        check("rst_tx",    32'(tx8),    32'd1);
        check("rst_ready", 32'(ready8), 32'd1);
        check("rst_busy",  32'(busy8),  32'd0);
        check("rst_done",  32'(done8),  32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // 0xA5 even, 1 stop: 0,1,0,1,0,0,1,0,1,0,1 over 11 periods
        run_frame(0, 9'h0A5, 3'd2, 1'b0);
        check_seq("a5_seq", 0, 16'b01010010101, 11);
        check("a5_ticks", 32'(trace_n[0]), 32'd12);
        check("a5_done",  32'(done_cnt[0]), 32'd1);

        // 0x07 odd, 2 stops: parity 0, then two stop 1s, 12 periods
        run_frame(0, 9'h007, 3'd1, 1'b1);
        check("07_odd_par",   32'(trace[0][9]),  32'd0);
        check("07_odd_stop1", 32'(trace[0][10]), 32'd1);
        check("07_odd_stop2", 32'(trace[0][11]), 32'd1);
        check("07_odd_ticks", 32'(trace_n[0]),   32'd13);
        run_frame(0, 9'h007, 3'd2, 1'b1);
        check("07_even_par",  32'(trace[0][9]),  32'd1);

        // 0x3C, no parity (000 and 111): 10-period frames, same waveform
        run_frame(0, 9'h03C, 3'd0, 1'b0);
        check_seq("3c_none_seq", 0, 16'b0001111001, 10);
        check("3c_none_ticks", 32'(trace_n[0]), 32'd11);
        run_frame(0, 9'h03C, 3'd7, 1'b0);
        check_seq("3c_111_seq", 0, 16'b0001111001, 10);
        check("3c_111_ticks", 32'(trace_n[0]), 32'd11);

        // width 5, 0x1F: mark then space, 8-period frames
        run_frame(1, 9'h01F, 3'd3, 1'b0);
        check("w5_mark_par",   32'(trace[1][6]), 32'd1);
        check("w5_mark_ticks", 32'(trace_n[1]),  32'd9);
        run_frame(1, 9'h01F, 3'd4, 1'b0);
        check("w5_space_par",   32'(trace[1][6]), 32'd0);
        check("w5_space_ticks", 32'(trace_n[1]),  32'd9);

        // reset while data bit 3 of 0xFF is on the line
        trace_n[0] = 0;
        send(0, 9'h0FF, 3'd2, 1'b0);
        n = 0;
        while (trace_n[0] < 5 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("rst_mid_reached", 32'(trace_n[0]), 32'd5);
        check("rst_mid_tx_before", 32'(tx8), 32'd1);
        dc = done_cnt[0];
        #2 reset = 1'b1;
        #1;
        check("rst_mid_tx",    32'(tx8),    32'd1);
        check("rst_mid_busy",  32'(busy8),  32'd0);
        check("rst_mid_ready", 32'(ready8), 32'd1);
        check("rst_mid_done",  32'(done8),  32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (20) @(negedge clock);
        check("rst_mid_no_done", 32'(done_cnt[0]), 32'(dc));
        check("rst_after_ready", 32'(ready8), 32'd1);
        run_frame(0, 9'h0A5, 3'd2, 1'b0);
        check_seq("post_rst_seq", 0, 16'b01010010101, 11);
        check("post_rst_ticks", 32'(trace_n[0]), 32'd12);

        // back-to-back with data_valid held: 0x11 (none) then 0x22 (odd,
        // parity_type changed while the first frame is in flight)
        trace_n[0]  = 0;
        done_cnt[0] = 0;
        data8       = 8'h11;
        parity_type = 3'd0;
        stop_bits   = 1'b0;
        valid8      = 1'b1;
        wait_model(0, 1'b1, 50, "b2b_accept1");
        data8       = 8'h22;
        parity_type = 3'd1;
        wait_model(0, 1'b0, 400, "b2b_end1");
        wait_model(0, 1'b1, 50, "b2b_accept2");
        valid8 = 1'b0;
        wait_model(0, 1'b0, 400, "b2b_end2");
        repeat (2) @(negedge clock);
        check("b2b_done_cnt", 32'(done_cnt[0]), 32'd2);
        check("b2b_ticks",    32'(trace_n[0]),  32'd23);
        check("b2b_stop1",    32'(trace[0][9]), 32'd1);
        check("b2b_idle_gap", 32'(trace[0][10]), 32'd1);
        check("b2b_start2",   32'(trace[0][11]), 32'd0);
        check("b2b_par2",     32'(trace[0][20]), 32'd1);

        // random frames on both widths, random tick period
        for (int r = 0; r < 40; r++) begin
            int          inst;
            logic [8:0]  d;
            inst        = int'($urandom_range(0, 1));
            tick_period = int'($urandom_range(2, 6));
            d           = 9'($urandom);
            send(inst, d, 3'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 1) wait_model(inst, 1'b0, 400, "rand_end");
        end
        wait_model(0, 1'b0, 400, "final_idle_w8");
        wait_model(1, 1'b0, 400, "final_idle_w5");
        repeat (4) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_framer.md
# uart_tx_framer

Parametrised UART transmit framer: accepts one data word over a valid/ready handshake and serialises it LSB-first as start bit, DATA_WIDTH data bits, optional parity bit and 1 or 2 stop bits, one bit per baud tick. Parity is accumulated serially as bits shift out, and supports odd, even, mark, space and none. It sits between the TX input register stage and the line driver, replacing the standalone combinational parity generator on the TX path.

## Interface

- DATA_WIDTH, 8, data bits per frame; legal range 5..9.
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_in  in  DATA_WIDTH  word to transmit; sampled on accept.
- data_valid  in  1  word present on data_in.
- data_ready  out  1  framer can accept a word; high only in IDLE.
- parity_type  in  3  000 none, 001 odd, 010 even, 011 mark, 100 space, 101..111 none; sampled on accept.
- stop_bits  in  1  0 = one stop bit, 1 = two; sampled on accept.
- baud_tick  in  1  single-cycle strobe, one per bit period.
- tx  out  1  serial line, idle high.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse when a frame completes.

## Operation

- Accept occurs when data_valid && data_ready, and only in IDLE. On accept:
  - latch data_in, parity_type and stop_bits;
  - clear the parity accumulator;
  - go to ARMED.
- Latched parameters are used for the whole frame. Input changes after accept are ignored.
- FSM states and transitions:
  - IDLE -> ARMED on accept.
  - ARMED -> START on baud_tick.
  - START -> DATA on baud_tick.
  - DATA -> DATA until DATA_WIDTH bits have been sent, then -> PARITY if parity is enabled, otherwise -> STOP.
  - PARITY -> STOP on baud_tick.
  - STOP -> STOP for a second stop bit when stop_bits=1, then -> IDLE on the tick that ends the last stop bit.
- tx is registered and changes only on edges where baud_tick=1:
  - ARMED->START drives 0.
  - Each DATA tick drives shift_reg[0] and shifts right.
  - The PARITY tick drives the parity bit.
  - STOP ticks drive 1.
- Parity accumulator XORs in each data bit as it is driven. The parity bit by mode:
  - odd: ~acc (total ones including parity is odd);
  - even: acc;
  - mark: 1;
  - space: 0;
  - none and 101..111: no parity slot.
- Counters:
  - bit_cnt is $clog2(DATA_WIDTH+1) wide and counts 0..DATA_WIDTH-1;
  - stop_cnt is 1 bit.
  - Neither wraps mid-frame.
- baud_tick in IDLE is ignored. data_valid outside IDLE is ignored, and the word is held by the producer.
- Reset (async, any state):
  - tx=1, state IDLE, data_ready=1, busy=0, done=0;
  - counters, shift register and accumulator all cleared.
  - An in-flight frame is discarded and produces no done.

## Timing

- Reset values: tx=1, data_ready=1, busy=0, done=0.
- data_ready falls, and busy rises, on the edge after accept.
- Start bit begins on the first baud_tick edge after entering ARMED. Accept and tick in the same cycle does not start the frame; the start bit waits for the next tick.
- Every bit lasts exactly one tick period.
- Frame length is 1 + DATA_WIDTH + P + S tick periods, where P is 0 or 1 and S is 1 or 2.
- done pulses for one cycle on the tick edge that ends the last stop bit; state returns to IDLE on the same edge.
- Back-to-back frames with data_valid held high are separated by exactly one idle (high) bit period.

## Structure

- Shared package uart_pkg holds:
  - parity_t enum (3-bit: PAR_NONE, PAR_ODD, PAR_EVEN, PAR_MARK, PAR_SPACE);
  - tx_state_t enum (IDLE, ARMED, START, DATA, PARITY, STOP);
  - localparams MIN_DATA_WIDTH=5 and MAX_DATA_WIDTH=9.
- One sub-module, uart_parity_acc: clear/enable/bit inputs and a parity_type-to-parity_bit mux. It is reused later by the RX checker.
- Elaboration-time assertion that DATA_WIDTH is within 5..9.

## Test plan

- DATA_WIDTH=8, 0xA5, even, 1 stop -> tx per tick 0,1,0,1,0,0,1,0,1,0,1, then done after 11 periods.
- 0x07, odd, 2 stops -> parity slot 0, two stop 1s, done after 12 periods. Same word with even gives a parity slot of 1.
- 0x3C with parity_type 000 and again with 111 -> 10-period frames, no parity slot, identical waveforms.
- DATA_WIDTH=5, 0x1F, mark then space -> parity slot 1, then 0; frame length 8 periods.
- Reset asserted while driving data bit 3 of 0xFF -> tx=1 immediately and busy=0, no done pulse. After release, data_ready=1 and the next frame is correct.
- data_valid held high, words 0x11 then 0x22 -> done pulses twice, exactly one idle-high period between frames. parity_type changed mid-frame does not affect the current frame.
